// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ requesters and a single FIFO write port.
// Carries requests, per-requester data/last, the FIFO full flag and grant results.
// The slave modport is the arbiter; the master modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic                          wfull;
    logic [NUM_REQ-1:0]            gnt;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          locked;

    modport master (
        output req, req_data, req_last, wfull,
        input  gnt, winc, wdata, locked
    );

    modport slave (
        input  req, req_data, req_last, wfull,
        output gnt, winc, wdata, locked
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter muxing NUM_REQ writers onto one FIFO write port; optional burst lock (macro ARB_LOCK_EN).
// Latency: zero -- gnt/winc/wdata are combinational from req, wfull and registered pointer/lock state.
// Backpressure: wfull=1 suppresses every grant and freezes pointer, lock state and beat counter.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q;
    logic             sel_vld;
    logic [PTR_W-1:0] sel_idx;

    // Index following i in round-robin order, wrapping NUM_REQ-1 back to 0.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

`ifdef ARB_LOCK_EN
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  owner_q;
    logic [BEAT_W-1:0] beat_cnt_q;
`else
    // Without burst locking every grant is single-beat, so req_last carries no meaning.
    logic unused_req_last;
    assign unused_req_last = ^bus.req_last;
`endif

    // Pick the winner: the lock owner while locked, else first requester at or above rr_ptr.
    always_comb begin
        int idx;
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        if (!wrst && !bus.wfull) begin
`ifdef ARB_LOCK_EN
            if (state_q == LOCK) begin
                if (bus.req[owner_q]) begin
                    sel_vld = 1'b1;
                    sel_idx = owner_q;
                end
            end else
`endif
            begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                    if (!sel_vld && bus.req[idx]) begin
                        sel_vld = 1'b1;
                        sel_idx = PTR_W'(idx);
                    end
                end
            end
        end
    end

    // Drive the FIFO write port and one-hot grant from the selected requester.
    always_comb begin
        bus.gnt   = '0;
        bus.winc  = sel_vld;
        bus.wdata = '0;
        if (sel_vld) begin
            bus.gnt[sel_idx] = 1'b1;
            bus.wdata        = bus.req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef ARB_LOCK_EN
    assign bus.locked = !wrst && (state_q == LOCK);

    // Lock FSM: open a burst on a non-last ARB grant, close it on last beat or MAX_BURST.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else if (sel_vld) begin
            if (state_q == ARB) begin
                if (!bus.req_last[sel_idx] && (MAX_BURST > 1)) begin
                    state_q    <= LOCK;
                    owner_q    <= sel_idx;
                    beat_cnt_q <= BEAT_W'(1);
                end else begin
                    rr_ptr_q <= ptr_after(sel_idx);
                end
            end else begin
                if (bus.req_last[owner_q] || (int'(beat_cnt_q) + 1 == MAX_BURST)) begin
                    state_q    <= ARB;
                    beat_cnt_q <= '0;
                    rr_ptr_q   <= ptr_after(owner_q);
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
        end
    end
`else
    assign bus.locked = 1'b0;

    // Every grant ends arbitration: advance the pointer past the winner.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            rr_ptr_q <= '0;
        end else if (sel_vld) begin
            rr_ptr_q <= ptr_after(sel_idx);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, hand sequences, randomized run vs reference model.
// Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
// Lock sequences are compiled only when ARB_LOCK_EN is defined.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic wclk = 1'b0;
    logic wrst;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.slave)
    );

    always #5 wclk = ~wclk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] d [NR];

    // Reference model state
    int m_ptr;
    bit m_lock;
    int m_owner;
    int m_beats;

    typedef struct {
        logic [NR-1:0] req;
        logic          wfull;
        logic [NR-1:0] gnt;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put_data();
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = d[i];
    endtask

    task automatic check_outputs(input string tag, input logic [NR-1:0] eg, input logic el);
        logic [DW-1:0] ed;
        ed = '0;
        for (int i = 0; i < NR; i++) if (eg[i]) ed = d[i];
        check({tag, ".gnt"},    64'(bus.gnt),    64'(eg));
        check({tag, ".winc"},   64'(bus.winc),   64'(|eg));
        check({tag, ".wdata"},  64'(bus.wdata),  64'(ed));
        check({tag, ".locked"}, 64'(bus.locked), 64'(el));
    endtask

    // One cycle: drive at edge+1, check at falling edge, advance past next edge.
    task automatic step(input string tag, input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input logic wf, input logic [NR-1:0] eg, input logic el);
        bus.req      = r;
        bus.req_last = l;
        bus.wfull    = wf;
        put_data();
        #4;
        check_outputs(tag, eg, el);
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        wrst = 1'b1;
        bus.req      = '1;
        bus.req_last = '0;
        bus.wfull    = 1'b0;
        put_data();
        #2;
        check_outputs({tag, ".in_reset"}, '0, 1'b0);
        @(posedge wclk);
        #1;
        wrst    = 1'b0;
        m_ptr   = 0;
        m_lock  = 1'b0;
        m_owner = 0;
        m_beats = 0;
    endtask

    // Expected grant index from the arbitration rules, -1 when nothing is granted.
    function automatic int predict(input logic [NR-1:0] r, input logic wf);
        if (wf) return -1;
        if (m_lock) return r[m_owner] ? m_owner : -1;
        for (int k = 0; k < NR; k++) if (r[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return -1;
    endfunction

    task automatic model_update(input int g, input logic [NR-1:0] l);
        if (g < 0) return;
        if (!m_lock) begin
            if (LOCK_EN && !l[g] && MB > 1) begin
                m_lock  = 1'b1;
                m_owner = g;
                m_beats = 1;
            end else begin
                m_ptr = (g + 1) % NR;
            end
        end else if (l[m_owner] || m_beats + 1 == MB) begin
            m_lock  = 1'b0;
            m_beats = 0;
            m_ptr   = (m_owner + 1) % NR;
        end else begin
            m_beats++;
        end
    endtask

    initial begin
        logic [NR-1:0] r, l, eg;
        logic          wf;
        int            g;

        vt[0]  = '{4'b1111, 1'b0, 4'b0001};
        vt[1]  = '{4'b1111, 1'b0, 4'b0010};
        vt[2]  = '{4'b1111, 1'b0, 4'b0100};
        vt[3]  = '{4'b1111, 1'b0, 4'b1000};
        vt[4]  = '{4'b0000, 1'b0, 4'b0000};
        vt[5]  = '{4'b0101, 1'b0, 4'b0001};
        vt[6]  = '{4'b0101, 1'b1, 4'b0000};
        vt[7]  = '{4'b0101, 1'b0, 4'b0100};
        vt[8]  = '{4'b0101, 1'b0, 4'b0001};
        vt[9]  = '{4'b0100, 1'b0, 4'b0100};
        vt[10] = '{4'b1001, 1'b0, 4'b1000};
        vt[11] = '{4'b1001, 1'b0, 4'b0001};
        vt[12] = '{4'b0110, 1'b1, 4'b0000};
        vt[13] = '{4'b0011, 1'b0, 4'b0010};
        vt[14] = '{4'b0011, 1'b0, 4'b0001};

        d[0] = 32'h1111_1111;
        d[1] = 32'h2222_2222;
        d[2] = 32'hA5A5_A5A5;
        d[3] = 32'h4444_4444;

        wrst         = 1'b0;
        bus.req      = '0;
        bus.req_last = '0;
        bus.wfull    = 1'b0;
        put_data();
        @(posedge wclk);
        #1;
        do_reset("rst0");

        // Single-beat vectors (req_last all set so the lock build behaves identically)
        for (int i = 0; i < 15; i++)
            step($sformatf("vec%0d", i), vt[i].req, 4'b1111, vt[i].wfull, vt[i].gnt, 1'b0);

`ifdef ARB_LOCK_EN
        do_reset("rst_lock");
        // Full-length burst by requester 0, then requester 1 gets the bus
        step("burst.b1", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0);
        step("burst.b2", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1);
        step("burst.b3", 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1);
        step("burst.b3r", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1);
        step("burst.stall", 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1);
        step("burst.b4", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1);
        step("own1.b1", 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0);
        step("own1.b2", 4'b0011, 4'b0010, 1'b0, 4'b0010, 1'b1);
        step("after_last", 4'b0011, 4'b1111, 1'b0, 4'b0001, 1'b0);
        step("own1again", 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0);
        // Reset pulse while the lock is held
        bus.req      = 4'b0010;
        bus.req_last = 4'b0000;
        bus.wfull    = 1'b0;
        #4;
        check_outputs("lock_held", 4'b0010, 1'b1);
        do_reset("rst_mid_lock");
        step("post_rst", 4'b0011, 4'b1111, 1'b0, 4'b0001, 1'b0);
`endif

        // Randomized run against the reference model, with occasional resets
        do_reset("rst_rand");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset($sformatf("rnd_rst%0d", c));
            end
            r  = NR'($urandom_range(0, (1 << NR) - 1));
            l  = NR'($urandom_range(0, (1 << NR) - 1));
            wf = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++) d[i] = $urandom;
            g  = predict(r, wf);
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            bus.req      = r;
            bus.req_last = l;
            bus.wfull    = wf;
            put_data();
            #4;
            check_outputs($sformatf("rnd%0d", c), eg, m_lock);
            model_update(g, l);
            @(posedge wclk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, FIFO word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, max beats per locked burst (1..16).
REQ-004 SHALL have port wclk  input  1  sole clock; one clock, all state on rising edge.
REQ-005 SHALL have port wrst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request; held until granted.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last  input  NUM_REQ  final beat of burst; used only with ARB_LOCK_EN.
REQ-009 SHALL have port wfull  input  1  FIFO write-side full flag.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot acceptance; req_data[i] consumed this cycle.
REQ-011 SHALL have port winc  output  1  FIFO write strobe.
REQ-012 SHALL have port wdata  output  DATA_WIDTH  FIFO write data.
REQ-013 SHALL have port locked  output  1  high while a burst lock is held.

Function
REQ-014 SHALL drive gnt, winc, wdata combinationally from req, wfull and registered state; zero-latency acceptance.
REQ-015 SHALL assert winc = OR(gnt) and wdata = req_data of granted index; wdata = 0 when no grant.
REQ-016 SHALL never assert gnt or winc while wfull = 1; state, pointer and beat counter hold.
REQ-017 In ARB state, SHALL grant the first requester with req = 1 searching from rr_ptr upward, wrapping NUM_REQ-1 to 0.
REQ-018 SHALL assert at most one gnt bit per cycle.
REQ-019 On a grant to index i that ends arbitration, SHALL update rr_ptr to (i+1) mod NUM_REQ on the same edge.
REQ-020 With no req and wfull = 0, SHALL keep gnt = 0, winc = 0, state unchanged.
REQ-021 SHALL treat req deassertion before grant as withdrawal; no grant, no pointer change.

Reset
REQ-022 While wrst = 1, SHALL force gnt = 0, winc = 0, wdata = 0, locked = 0, regardless of inputs.
REQ-023 On wrst assertion, SHALL asynchronously set rr_ptr = 0, state = ARB, owner = 0, beat_cnt = 0.
REQ-024 Reset mid-burst SHALL discard the lock; first cycle after release arbitrates from index 0.

Configuration
REQ-025 Macro ARB_LOCK_EN SHALL enable burst locking; without it req_last is ignored, locked = 0, every grant is single-beat, state stays ARB.
REQ-026 With ARB_LOCK_EN, a grant in ARB to i with req_last[i] = 0 and MAX_BURST > 1 SHALL enter LOCK, owner = i, beat_cnt = 1, rr_ptr unchanged.
REQ-027 In LOCK, SHALL grant only owner, when req[owner] = 1 and wfull = 0; other requests ignored.
REQ-028 In LOCK, req[owner] = 0 SHALL stall with lock held, no grant.
REQ-029 In LOCK, a grant with req_last[owner] = 1 or beat_cnt+1 = MAX_BURST SHALL return to ARB and set rr_ptr = (owner+1) mod NUM_REQ.
REQ-030 In LOCK, other grants SHALL increment beat_cnt; locked = 1 exactly while state = LOCK.
REQ-031 Grant in ARB with req_last[i] = 1 SHALL be single-beat, ending arbitration per REQ-019.

Verification
REQ-032 Reset, then req = 4'b1111, wfull = 0, 4 cycles -> gnt 0001, 0010, 0100, 1000; winc = 1 each cycle; wdata matches slice.
REQ-033 req = 4'b0101 held, wfull toggling 0,1,0 -> gnt 0001, 0000, 0100; winc = 0 in wfull cycle; rr_ptr unchanged during wfull.
REQ-034 Single req[2] = 1, data 0xA5A5A5A5 -> gnt = 0100, winc = 1, wdata = 0xA5A5A5A5; next grant search starts at 3.
REQ-035 ARB_LOCK_EN, MAX_BURST = 4, req = 4'b0011, req_last = 0 -> gnt 0001 x4, locked = 1 for 3 cycles, then 0010.
REQ-036 ARB_LOCK_EN, owner 1, req_last[1] = 1 on beat 2 -> exits LOCK after beat 2; wrst pulse during LOCK -> locked = 0, next grant from index 0.
